adc_scan_sequencer: RTL and testbench
=====================================

Name: adc_scan_sequencer

Overview:
- Sequences conversions on the board's LTC2308 8-channel, 12-bit SPI ADC (ADC_CONVST / ADC_SCK / ADC_SDI / ADC_SDO pins).
- Scans a channel mask, either once or continuously, and handles the ADC's one-frame result pipeline.
- Delivers each tagged 12-bit result as a single-cycle valid strobe toward the HPS-visible register/PIO layer.

Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles; 12.5 MHz SCK at 50 MHz.
- CONV_CYCLES, 80: conversion wait with CONVST low, in clk cycles; 1.6 us at 50 MHz.

Ports:
- clk  in  1  FPGA_CLK1_50 domain clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a scan.
- continuous  in  1  1 = repeat scans until deasserted.
- ch_mask  in  8  enabled channels; bit n = CH n.
- uni  in  1  1 = unipolar, 0 = bipolar.
- busy  out  1  scan in progress.
- result_valid  out  1  one-cycle strobe.
- result_ch  out  3  channel number of result_data.
- result_data  out  12  conversion result.
- adc_convst  out  1  to ADC_CONVST.
- adc_sck  out  1  to ADC_SCK.
- adc_sdi  out  1  to ADC_SDI.
- adc_sdo  in  1  from ADC_SDO.

Behaviour:
- Reset (async): all outputs 0, FSM to IDLE, priming flag set. Reset mid-frame aborts the frame immediately, with no result strobe.
- IDLE:
  - start with busy=0 and ch_mask!=0: latch ch_mask and uni, busy=1, go to CONVST.
  - start while busy=1 is ignored.
  - start with ch_mask=0 is ignored; busy stays 0.
- CONVST: adc_convst=1 for 2 cycles, then go to CONV_WAIT.
- CONV_WAIT: adc_convst=0 for CONV_CYCLES cycles, then go to SHIFT.
- SHIFT: 12 SCK periods.
  - adc_sck idles low; each period is CLK_DIV cycles low, then CLK_DIV cycles high.
  - adc_sdo is sampled on the clk where adc_sck rises, MSB first, into a 12-bit shifter.
  - adc_sdi carries a 6-bit config word, MSB first. The word is valid from SHIFT entry and advances on the clk where adc_sck falls; bits 7-12 are 0.
- Config word for channel c: {1, c[0], c[2], c[1], uni_latched, 0} (single-ended, sleep off).
- DONE (1 cycle):
  - If the frame is not a priming frame: result_valid=1, result_data = shifter, result_ch = channel configured in the previous frame.
  - Then go to CONVST for the next frame, or to IDLE (busy=0 in the same cycle).
- Frame length: 2 + CONV_CYCLES + 24*CLK_DIV + 1 clk cycles (131 with defaults).
- Pipeline: each frame sends the config of the next channel and receives the result of the previous config.
  - First frame after IDLE is a priming frame; its result is discarded.
  - A scan of N enabled channels (ascending order) takes N+1 frames when primed. The final frame sends the config of the first enabled channel as a dummy.
- Continuous mode:
  - The final frame of a scan doubles as the first frame of the next scan; no re-priming.
  - ch_mask and uni are re-latched at each scan boundary (DONE of a scan's last result).
  - Deasserting continuous mid-scan lets the current scan and its trailing frame complete, then the FSM returns to IDLE.
- result_data and result_ch hold their value until the next strobe.

Test Plan:
- ch_mask=0x05, uni=1, start, ADC model returns 0x123 (CH0) and 0xABC (CH2).
  - Expect 3 frames of 131 cycles; SDI words 100010, 100110, 100010.
  - Strobes {ch0, 0x123} at end of frame 2 and {ch2, 0xABC} at end of frame 3.
  - busy falls in the cycle of the final DONE.
- ch_mask=0x00, start -> adc_convst stays 0, busy stays 0, no strobe.
- Second start pulse issued mid-frame with a different mask -> ignored; frame count and SDI words unchanged.
- ch_mask=0x80, continuous=1, start.
  - SDI word is 111110 in every frame; one priming frame.
  - Strobes {ch7} every 131 cycles.
  - Drop continuous mid-frame -> exactly one more strobe, then busy=0.
- SCK/SDO timing:
  - 12 rising edges per frame, 4-cycle SCK period, adc_sck=0 outside SHIFT.
  - Model SDO changing after each falling edge is captured bit-exact (0x5A5).
- Assert reset during SHIFT -> adc_sck, adc_convst, busy and result_valid are 0 immediately with no strobe; the next start performs a priming frame again.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
//
// Drives an LTC2308 8-channel 12-bit SPI ADC through a scan of the enabled
// channels in ch_mask (ascending order), either once or continuously. Each frame
// pulses CONVST, waits out the conversion, then clocks 12 SCK periods. During
// those periods it sends the config word for the NEXT channel and receives the
// result of the PREVIOUS config. The first frame after idle only primes this
// pipeline. Each result is tagged with its channel and presented with a
// one-cycle result_valid strobe.
//
// Ports
//   clk           system clock (50 MHz domain)
//   reset         asynchronous, active-high reset
//   start         one-cycle pulse, begins a scan when idle and ch_mask != 0
//   continuous    1 = keep rescanning until deasserted
//   ch_mask[7:0]  enabled channels, bit n = CH n
//   uni           1 = unipolar, 0 = bipolar
//   busy          scan in progress
//   result_valid  one-cycle result strobe
//   result_ch     channel of result_data (held until the next strobe)
//   result_data   12-bit conversion result (held until the next strobe)
//   adc_convst    to ADC_CONVST
//   adc_sck       to ADC_SCK (idles low)
//   adc_sdi       to ADC_SDI
//   adc_sdo       from ADC_SDO
// -----------------------------------------------------------------------------
module adc_scan_sequencer #(
  parameter int CLK_DIV     = 2,   // SCK half-period in clk cycles
  parameter int CONV_CYCLES = 80   // conversion wait in clk cycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic [7:0]  ch_mask,
  input  logic        uni,
  output logic        busy,
  output logic        result_valid,
  output logic [2:0]  result_ch,
  output logic [11:0] result_data,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVST,
    S_CONV_WAIT,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  localparam logic [CNT_W-1:0] CONVST_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(CONV_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);

  // Lowest enabled channel in m.
  function automatic logic [2:0] first_ch(input logic [7:0] m);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) c = 3'(i);
    end
    return c;
  endfunction

  // {found, channel}: lowest enabled channel strictly above cur.
  function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (3'(i) > cur)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Single-ended, sleep off. The ADC address order is odd/sign, select1, select0.
  function automatic logic [5:0] cfg_word(input logic [2:0] c, input logic u);
    return {1'b1, c[0], c[2], c[1], u, 1'b0};
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic              sck_q, sck_d;
  logic [5:0]        sdi_q, sdi_d;
  logic [11:0]       shift_q, shift_d;
  logic [7:0]        mask_q, mask_d;
  logic              uni_q, uni_d;
  logic [2:0]        cfg_ch_q, cfg_ch_d;   // channel whose config this frame sends
  logic [2:0]        res_ch_q, res_ch_d;   // channel whose result this frame returns
  logic              priming_q, priming_d; // this frame's result is meaningless
  logic              wrap_q, wrap_d;       // this frame delivers the scan's last result
  logic              stop_q, stop_d;       // return to idle after this frame's DONE
  logic [2:0]        result_ch_q, result_ch_d;
  logic [11:0]       result_data_q, result_data_d;

  logic              half_done;
  logic              last_fall;
  logic [7:0]        scan_mask;
  logic [3:0]        nxt;

  assign half_done = (state_q == S_SHIFT) && (div_q == DIV_LAST);
  assign last_fall = half_done && sck_q && (bit_q == 4'd11);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of process order.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default at the top of every combinational block means no path
    // leaves a variable unassigned, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start && (ch_mask != 8'd0)) state_d = S_CONVST;
      S_CONVST:    if (cnt_q == CONVST_LAST)      state_d = S_CONV_WAIT;
      S_CONV_WAIT: if (cnt_q == WAIT_LAST)        state_d = S_SHIFT;
      S_SHIFT:     if (last_fall)                 state_d = S_DONE;
      S_DONE:      state_d = stop_q ? S_IDLE : S_CONVST;
      default:     state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registers only)
  // ---------------------------------------------------------------------------
  always_comb begin
    // busy drops already in the final DONE cycle, alongside the last strobe.
    busy         = (state_q != S_IDLE) && !((state_q == S_DONE) && stop_q);
    result_valid = (state_q == S_DONE) && !priming_q;
    adc_convst   = (state_q == S_CONVST);
  end

  assign adc_sck     = sck_q;
  assign adc_sdi     = sdi_q[5];
  assign result_ch   = result_ch_q;
  assign result_data = result_data_q;

  // ---------------------------------------------------------------------------
  // Datapath: next values
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d         = '0;
    div_d         = div_q;
    bit_d         = bit_q;
    sck_d         = sck_q;
    sdi_d         = sdi_q;
    shift_d       = shift_q;
    mask_d        = mask_q;
    uni_d         = uni_q;
    cfg_ch_d      = cfg_ch_q;
    res_ch_d      = res_ch_q;
    priming_d     = priming_q;
    wrap_d        = wrap_q;
    stop_d        = stop_q;
    result_ch_d   = result_ch_q;
    result_data_d = result_data_q;
    scan_mask     = mask_q;
    nxt           = 4'd0;

    if (((state_q == S_CONVST) || (state_q == S_CONV_WAIT)) && (state_d == state_q))
      cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (state_d == S_CONVST) begin
          mask_d    = ch_mask;
          uni_d     = uni;
          cfg_ch_d  = first_ch(ch_mask);
          priming_d = 1'b1;
          wrap_d    = 1'b0;
          stop_d    = 1'b0;
        end
      end

      S_CONV_WAIT: begin
        // Config MSB must already be on SDI when SHIFT is entered.
        if (state_d == S_SHIFT) begin
          sdi_d = cfg_word(cfg_ch_q, uni_q);
          div_d = '0;
          bit_d = 4'd0;
          sck_d = 1'b0;
        end
      end

      S_SHIFT: begin
        if (half_done) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            shift_d = {shift_q[10:0], adc_sdo};   // SCK rising: capture SDO
          end else begin
            sdi_d = {sdi_q[4:0], 1'b0};           // SCK falling: advance SDI
            bit_d = bit_q + 4'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
        if (last_fall) begin
          stop_d = wrap_q && !(continuous && (ch_mask != 8'd0));
          if (!priming_q) begin
            result_ch_d   = res_ch_q;
            result_data_d = shift_q;
          end
        end
      end

      S_DONE: begin
        if (!stop_q) begin
          // A scan boundary in continuous mode picks up the live mask and mode;
          // the trailing frame already counts as the new scan's first frame.
          if (wrap_q && (ch_mask != 8'd0)) begin
            scan_mask = ch_mask;
            mask_d    = ch_mask;
            uni_d     = uni;
          end
          nxt       = next_ch(scan_mask, cfg_ch_q);
          res_ch_d  = cfg_ch_q;
          priming_d = 1'b0;
          cfg_ch_d  = nxt[3] ? nxt[2:0] : first_ch(scan_mask);
          wrap_d    = ~nxt[3];
        end
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      div_q         <= '0;
      bit_q         <= 4'd0;
      sck_q         <= 1'b0;
      sdi_q         <= 6'd0;
      shift_q       <= 12'd0;
      mask_q        <= 8'd0;
      uni_q         <= 1'b0;
      cfg_ch_q      <= 3'd0;
      res_ch_q      <= 3'd0;
      priming_q     <= 1'b1;
      wrap_q        <= 1'b0;
      stop_q        <= 1'b0;
      result_ch_q   <= 3'd0;
      result_data_q <= 12'd0;
    end else begin
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      sck_q         <= sck_d;
      sdi_q         <= sdi_d;
      shift_q       <= shift_d;
      mask_q        <= mask_d;
      uni_q         <= uni_d;
      cfg_ch_q      <= cfg_ch_d;
      res_ch_q      <= res_ch_d;
      priming_q     <= priming_d;
      wrap_q        <= wrap_d;
      stop_q        <= stop_d;
      result_ch_q   <= result_ch_d;
      result_data_q <= result_data_d;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_sequencer
//
// Directed bench for adc_scan_sequencer with a behavioural LTC2308 model. The
// model captures the 6-bit config on SCK rising edges, converts that channel at
// the next CONVST and shifts the stored per-channel value out on SDO, changing
// after each SCK falling edge. One-shot scans come from a vector table; the
// ignored start, continuous mode and reset-abort cases are hand-written.
// Timing is measured in clk periods (10 time units).
// -----------------------------------------------------------------------------
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        continuous;
  logic [7:0]  ch_mask;
  logic        uni;
  logic        busy;
  logic        result_valid;
  logic [2:0]  result_ch;
  logic [11:0] result_data;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo;

  always #5 clk = ~clk;

  adc_scan_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .ch_mask      (ch_mask),
    .uni          (uni),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ch    (result_ch),
    .result_data  (result_data),
    .adc_convst   (adc_convst),
    .adc_sck      (adc_sck),
    .adc_sdi      (adc_sdi),
    .adc_sdo      (adc_sdo)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // ADC model and monitors
  // ---------------------------------------------------------------------------
  logic [11:0] chan_val [8];
  logic [11:0] out_sh    = 12'hFFF;
  int          rise_n    = 0;
  logic [5:0]  cap       = 6'd0;
  logic        cap_valid = 1'b0;
  logic [2:0]  cap_ch    = 3'd0;

  longint      frame_t[$];
  logic [5:0]  words[$];
  int          sck_err    = 0;
  int          rise_total = 0;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
    logic [63:0] t;
  } strobe_t;

  strobe_t     strobes[$];
  logic        busy_ever   = 1'b0;
  logic        busy_fell   = 1'b0;
  logic        prev_busy   = 1'b0;
  longint      busy_fall_t = 0;

  assign adc_sdo = out_sh[11];

  always @(posedge adc_convst) begin
    frame_t.push_back($time);
    out_sh    = cap_valid ? chan_val[cap_ch] : 12'hFFF;
    cap_valid = 1'b0;
    rise_n    = 0;
  end

  always @(posedge adc_sck) begin
    if (frame_t.size() == 0 || ($time - frame_t[$]) != 10 * (84 + 4 * rise_n)) sck_err++;
    if (rise_n < 6) cap = {cap[4:0], adc_sdi};
    rise_n++;
    rise_total++;
    if (rise_n == 6) begin
      words.push_back(cap);
      cap_ch    = {cap[3], cap[2], cap[4]};
      cap_valid = 1'b1;
    end
  end

  always @(negedge adc_sck) begin
    if (frame_t.size() == 0 || ($time - frame_t[$]) != 10 * (86 + 4 * (rise_n - 1))) sck_err++;
    #1 out_sh = {out_sh[10:0], 1'b0};
  end

  always @(negedge clk) begin
    if (result_valid) strobes.push_back('{ch: result_ch, data: result_data, t: $time});
    if (busy) busy_ever = 1'b1;
    if (prev_busy && !busy) begin
      busy_fell   = 1'b1;
      busy_fall_t = $time;
    end
    prev_busy = busy;
  end

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0]        mask;
    logic              uni;
    logic [3:0]        n_frames;
    logic [2:0][5:0]   words;
    logic [3:0]        n_strobes;
    logic [1:0][2:0]   s_ch;
    logic [1:0][11:0]  s_data;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] m, input logic u, input logic [3:0] nf,
                              input logic [5:0] w0, input logic [5:0] w1, input logic [5:0] w2,
                              input logic [3:0] ns, input logic [2:0] c0, input logic [11:0] d0,
                              input logic [2:0] c1, input logic [11:0] d1);
    vec_t v;
    v.mask      = m;
    v.uni       = u;
    v.n_frames  = nf;
    v.words[0]  = w0;
    v.words[1]  = w1;
    v.words[2]  = w2;
    v.n_strobes = ns;
    v.s_ch[0]   = c0;
    v.s_data[0] = d0;
    v.s_ch[1]   = c1;
    v.s_data[1] = d1;
    return v;
  endfunction

  vec_t vecs [5];

  task automatic launch(input logic [7:0] m, input logic u, input logic c);
    @(negedge clk);
    frame_t.delete();
    words.delete();
    strobes.delete();
    sck_err    = 0;
    rise_total = 0;
    busy_fell  = 1'b0;
    busy_ever  = 1'b0;
    ch_mask    = m;
    uni        = u;
    continuous = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy_fell) break;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    check({tag, " frames"}, frame_t.size(), v.n_frames);
    check({tag, " words_n"}, words.size(), v.n_frames);
    for (int k = 0; k < int'(v.n_frames) && k < words.size(); k++)
      check($sformatf("%s word%0d", tag, k), words[k], v.words[k]);
    check({tag, " strobes_n"}, strobes.size(), v.n_strobes);
    for (int k = 0; k < int'(v.n_strobes) && k < strobes.size(); k++) begin
      check($sformatf("%s s%0d_ch", tag, k), strobes[k].ch, v.s_ch[k]);
      check($sformatf("%s s%0d_data", tag, k), strobes[k].data, v.s_data[k]);
      if (k + 1 < frame_t.size())
        check($sformatf("%s s%0d_offset", tag, k), (longint'(strobes[k].t) - frame_t[k+1]) / 10, 130);
    end
    for (int i = 1; i < frame_t.size(); i++)
      check($sformatf("%s frame_len%0d", tag, i), (frame_t[i] - frame_t[i-1]) / 10, 131);
    check({tag, " sck_timing_errs"}, sck_err, 0);
    check({tag, " sck_rises"}, rise_total, 12 * int'(v.n_frames));
    check({tag, " busy_ever"}, busy_ever, v.n_frames != 0);
    check({tag, " busy_fell"}, busy_fell, v.n_frames != 0);
    if (strobes.size() > 0)
      check({tag, " busy_fall_at_done"}, busy_fall_t, longint'(strobes[$].t));
    if (v.n_strobes != 0) begin
      check({tag, " data_hold"}, result_data, v.s_data[v.n_strobes - 1]);
      check({tag, " ch_hold"}, result_ch, v.s_ch[v.n_strobes - 1]);
    end
    check({tag, " idle_valid"}, result_valid, 0);
    check({tag, " idle_sck"}, adc_sck, 0);
    check({tag, " idle_convst"}, adc_convst, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;

    chan_val[0] = 12'h123;
    chan_val[1] = 12'h5A5;
    chan_val[2] = 12'hABC;
    chan_val[3] = 12'h333;
    chan_val[4] = 12'h444;
    chan_val[5] = 12'h555;
    chan_val[6] = 12'h666;
    chan_val[7] = 12'h7E1;

    //            mask   uni  nf  w0         w1         w2         ns  c0    d0       c1    d1
    vecs[0] = mk(8'h05, 1'b1, 3, 6'b100010, 6'b100110, 6'b100010, 2, 3'd0, 12'h123, 3'd2, 12'hABC);
    vecs[1] = mk(8'h00, 1'b0, 0, 6'b000000, 6'b000000, 6'b000000, 0, 3'd0, 12'h000, 3'd0, 12'h000);
    vecs[2] = mk(8'h82, 1'b0, 3, 6'b110000, 6'b111100, 6'b110000, 2, 3'd1, 12'h5A5, 3'd7, 12'h7E1);
    vecs[3] = mk(8'h80, 1'b1, 2, 6'b111110, 6'b111110, 6'b000000, 1, 3'd7, 12'h7E1, 3'd0, 12'h000);
    vecs[4] = mk(8'h01, 1'b0, 2, 6'b100000, 6'b100000, 6'b000000, 1, 3'd0, 12'h123, 3'd0, 12'h000);

    reset      = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    ch_mask    = 8'd0;
    uni        = 1'b0;

    // Reset state
    #12;
    check("reset busy", busy, 0);
    check("reset valid", result_valid, 0);
    check("reset convst", adc_convst, 0);
    check("reset sck", adc_sck, 0);
    check("reset sdi", adc_sdi, 0);
    check("reset ch", result_ch, 0);
    check("reset data", result_data, 0);
    @(negedge clk);
    reset = 1'b0;

    // One-shot scans
    for (int i = 0; i < 5; i++) begin
      launch(vecs[i].mask, vecs[i].uni, 1'b0);
      wait_done(vecs[i].mask == 8'd0 ? 300 : 1000);
      check_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Start pulse mid-frame with a different mask and mode is ignored
    launch(8'h05, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    ch_mask = 8'h80;
    uni     = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done(1000);
    check_vec(vecs[0], "restart_ignored");

    // Continuous single-channel scan, then drop continuous mid-frame
    launch(8'h80, 1'b1, 1'b1);
    for (int i = 0; i < 1000 && strobes.size() < 3; i++) @(negedge clk);
    check("cont three_strobes", strobes.size() >= 3, 1);
    if (strobes.size() >= 3) begin
      check("cont priming_offset", (longint'(strobes[0].t) - frame_t[0]) / 10, 261);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("cont s%0d_ch", k), strobes[k].ch, 7);
        check($sformatf("cont s%0d_data", k), strobes[k].data, 12'h7E1);
        if (k > 0)
          check($sformatf("cont s%0d_spacing", k), (longint'(strobes[k].t) - longint'(strobes[k-1].t)) / 10, 131);
      end
    end
    repeat (40) @(negedge clk);
    continuous = 1'b0;
    n0 = strobes.size();
    wait_done(400);
    check("cont tail_strobes", strobes.size() - n0, 1);
    check("cont busy_fell", busy_fell, 1);
    if (strobes.size() > 0)
      check("cont busy_fall_at_done", busy_fall_t, longint'(strobes[$].t));
    check("cont words_n", words.size(), frame_t.size());
    for (int k = 0; k < words.size(); k++)
      check($sformatf("cont word%0d", k), words[k], 6'b111110);

    // Reset during SHIFT of the second frame aborts with no strobe
    launch(8'h05, 1'b1, 1'b0);
    for (int i = 0; i < 600 && !(frame_t.size() >= 2 && adc_sck); i++) @(negedge clk);
    check("rst reached_shift", frame_t.size() >= 2 && adc_sck, 1);
    #2 reset = 1'b1;
    #1;
    check("rst sck", adc_sck, 0);
    check("rst convst", adc_convst, 0);
    check("rst busy", busy, 0);
    check("rst valid", result_valid, 0);
    repeat (3) @(negedge clk);
    check("rst no_strobe", strobes.size(), 0);
    reset = 1'b0;
    launch(8'h05, 1'b1, 1'b0);
    wait_done(1000);
    check_vec(vecs[0], "after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
